// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI serial-SRAM sequencer: command bytes,
// transfer geometry and FSM state encoding.
package spi_mem_pkg;

  localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
  localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
  localparam int unsigned SPI_XFER_BITS = 40;  // cmd + addr24 + data byte
  localparam int unsigned SPI_HDR_BITS  = 32;  // cmd + addr24

  typedef enum logic [2:0] {
    ST_GAP   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/spi_mem_rr_arb.sv
// Two-way round-robin arbiter for the SPI memory sequencer.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_req[1:0]   request per port (0 = fetch, 1 = data)
//   i_upd        update last_grant at end of a transaction
//   i_upd_port   port that was served
//   o_gnt[1:0]   one-hot grant (combinational)
module spi_mem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_port,
  output logic [1:0] o_gnt
);

  // Resets to 1 so the first tie after reset goes to port 0.
  logic r_last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_upd) begin
      r_last_grant <= i_upd_port;
    end
  end

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI-master sequencer sharing one serial SRAM between an instruction-fetch
// port (0, read only) and a CPU data port (1). Each transaction shifts out
// cmd + 24-bit address + data byte (40 bits, MSB first, spi_clk = clk/2)
// and captures one byte from spi_miso during the data phase.
// Optional feature: define SPI_WRITE_EN to enable port-1 writes (cmd 0x02).
// Ports:
//   clk, rst                     clock, async active-high reset
//   p0_req/p0_addr/p0_ack        fetch port (level req, 1-cycle ack)
//   p1_req/p1_addr/p1_we/
//   p1_wdata/p1_ack              data port
//   rdata                        last read byte, updated on read acks only
//   busy                         low only while idle and waiting for a req
//   spi_clk/spi_mosi/spi_miso/
//   spi_ce                       SPI pins, spi_ce active low
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [7:0]        p1_wdata,
  output logic              p1_ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_ce
);

  localparam int unsigned      GAP_W      = $clog2(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [5:0]       LAST_BIT   = 6'(SPI_XFER_BITS - 1);
  localparam logic [5:0]       FIRST_DATA = 6'(SPI_HDR_BITS);

  state_t             r_state,   w_state;
  logic [5:0]         r_bit_cnt, w_bit_cnt;
  logic               r_phase,   w_phase;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
  logic [39:0]        r_shift,   w_shift;
  logic [7:0]         r_rx,      w_rx;
  logic [7:0]         r_rdata,   w_rdata;
  logic               r_p0_ack,  w_p0_ack;
  logic               r_p1_ack,  w_p1_ack;
  logic               r_spi_clk, w_spi_clk;
  logic               r_spi_mosi, w_spi_mosi;
  logic               r_spi_ce,  w_spi_ce;
  logic               r_gnt1,    w_gnt1;
  logic               r_is_wr,   w_is_wr;
  logic               w_upd;

  logic [1:0]         w_req;
  logic [1:0]         w_arb_gnt;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [23:0]        w_addr24;
  logic               w_wr;
  logic [7:0]         w_cmd;
  logic [7:0]         w_wdata;
  logic [39:0]        w_load;

  assign w_req = {p1_req, p0_req};

  spi_mem_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_upd      (w_upd),
    .i_upd_port (r_gnt1),
    .o_gnt      (w_arb_gnt)
  );

  assign w_sel_addr = w_arb_gnt[1] ? p1_addr : p0_addr;
  assign w_addr24   = 24'(w_sel_addr);

`ifdef SPI_WRITE_EN
  assign w_wr    = w_arb_gnt[1] & p1_we;
  assign w_wdata = w_wr ? p1_wdata : '0;
`else
  logic w_unused;
  assign w_unused = ^{p1_we, p1_wdata};
  assign w_wr     = 1'b0;
  assign w_wdata  = '0;
`endif

  assign w_cmd  = w_wr ? SPI_CMD_WRITE : SPI_CMD_READ;
  assign w_load = {w_cmd, w_addr24, w_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_GAP;
      r_bit_cnt  <= '0;
      r_phase    <= 1'b0;
      r_gap_cnt  <= '0;
      r_shift    <= '0;
      r_rx       <= '0;
      r_rdata    <= '0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_spi_clk  <= 1'b0;
      r_spi_mosi <= 1'b0;
      r_spi_ce   <= 1'b1;
      r_gnt1     <= 1'b0;
      r_is_wr    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bit_cnt  <= w_bit_cnt;
      r_phase    <= w_phase;
      r_gap_cnt  <= w_gap_cnt;
      r_shift    <= w_shift;
      r_rx       <= w_rx;
      r_rdata    <= w_rdata;
      r_p0_ack   <= w_p0_ack;
      r_p1_ack   <= w_p1_ack;
      r_spi_clk  <= w_spi_clk;
      r_spi_mosi <= w_spi_mosi;
      r_spi_ce   <= w_spi_ce;
      r_gnt1     <= w_gnt1;
      r_is_wr    <= w_is_wr;
    end
  end

  // Pin outputs are registered, so each branch sets the value the pins
  // must show during the following cycle.
  always_comb begin
    w_state    = r_state;
    w_bit_cnt  = r_bit_cnt;
    w_phase    = r_phase;
    w_gap_cnt  = r_gap_cnt;
    w_shift    = r_shift;
    w_rx       = r_rx;
    w_rdata    = r_rdata;
    w_p0_ack   = 1'b0;
    w_p1_ack   = 1'b0;
    w_spi_clk  = r_spi_clk;
    w_spi_mosi = r_spi_mosi;
    w_spi_ce   = r_spi_ce;
    w_gnt1     = r_gnt1;
    w_is_wr    = r_is_wr;
    w_upd      = 1'b0;

    case (r_state)
      ST_GAP: begin
        // Single spi_clk pulse with CE high resyncs the memory's decoder.
        w_spi_ce = 1'b1;
        if (r_gap_cnt == GAP_LAST) begin
          w_spi_clk = 1'b0;
          w_state   = ST_IDLE;
        end else begin
          w_spi_clk = (r_gap_cnt == '0);
          w_gap_cnt = r_gap_cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        if (|w_arb_gnt) begin
          w_gnt1     = w_arb_gnt[1];
          w_is_wr    = w_wr;
          w_shift    = w_load;
          w_spi_ce   = 1'b0;
          w_spi_clk  = 1'b0;
          w_spi_mosi = w_load[39];
          w_bit_cnt  = '0;
          w_phase    = 1'b0;
          w_state    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!r_phase) begin
          w_spi_clk = 1'b1;
          w_phase   = 1'b1;
        end else begin
          if (r_bit_cnt >= FIRST_DATA) begin
            w_rx = {r_rx[6:0], spi_miso};
          end
          w_spi_clk = 1'b0;
          w_phase   = 1'b0;
          if (r_bit_cnt == LAST_BIT) begin
            w_spi_ce   = 1'b1;
            w_spi_mosi = 1'b0;
            w_state    = ST_DONE;
          end else begin
            w_shift    = {r_shift[38:0], 1'b0};
            w_spi_mosi = r_shift[38];
            w_bit_cnt  = r_bit_cnt + 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_p0_ack  = ~r_gnt1;
        w_p1_ack  = r_gnt1;
        if (!r_is_wr) begin
          w_rdata = r_rx;
        end
        w_upd     = 1'b1;
        w_gap_cnt = '0;
        w_state   = ST_GAP;
      end

      default: begin
        w_state = ST_GAP;
      end
    endcase
  end

  assign p0_ack   = r_p0_ack;
  assign p1_ack   = r_p1_ack;
  assign rdata    = r_rdata;
  assign busy     = (r_state != ST_IDLE);
  assign spi_clk  = r_spi_clk;
  assign spi_mosi = r_spi_mosi;
  assign spi_ce   = r_spi_ce;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a serial-SRAM model that returns
// (addr[2:0] + 1) for every read and a scoreboard of expected acks.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 1'b0;
  logic [15:0] p0_addr = '0;
  logic        p0_ack;
  logic        p1_req = 1'b0;
  logic [15:0] p1_addr = '0;
  logic        p1_we = 1'b0;
  logic [7:0]  p1_wdata = '0;
  logic        p1_ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_ce;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.ADDR_W(16), .GAP_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_addr  (p0_addr),
    .p0_ack   (p0_ack),
    .p1_req   (p1_req),
    .p1_addr  (p1_addr),
    .p1_we    (p1_we),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .rdata    (rdata),
    .busy     (busy),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ce   (spi_ce)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         port;
    logic [7:0] rd;
  } exp_t;
  exp_t sb[$];

  // Memory model: samples mosi on spi_clk rise, drives miso on spi_clk rise
  // during the data byte, records the frame when CE rises and counts
  // spi_clk pulses seen with CE high.
  logic [39:0] m_rec = '0;
  logic [39:0] last_frame = '0;
  int          m_bits = 0;
  int          last_bits = 0;
  int          gap_pulses = 0;
  int          last_gap = 0;
  logic [7:0]  m_byte = '0;
  logic        ce_q = 1'b1;

  always @(posedge spi_clk or spi_ce) begin
    if (spi_ce !== ce_q) begin
      if (spi_ce === 1'b1) begin
        last_frame = m_rec;
        last_bits  = m_bits;
        gap_pulses = 0;
      end else begin
        m_bits   = 0;
        m_rec    = '0;
        last_gap = gap_pulses;
      end
      ce_q = spi_ce;
    end else if (spi_clk === 1'b1) begin
      if (spi_ce === 1'b1) begin
        gap_pulses++;
      end else begin
        if (m_bits == 32) m_byte = 8'(m_rec[2:0]) + 8'd1;
        if (m_bits >= 32 && m_bits < 40) spi_miso = m_byte[39 - m_bits];
        m_rec = {m_rec[38:0], spi_mosi};
        m_bits++;
      end
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ack();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=ack expected=no_ack");
    end else begin
      e = sb.pop_front();
      chk("ack_port", 40'({p1_ack, p0_ack}), 40'((e.port == 0) ? 2'b01 : 2'b10));
      chk("rdata", 40'(rdata), 40'(e.rd));
    end
  endtask

  task automatic wait_ack(output logic got);
    int k;
    k = 0;
    got = 1'b0;
    while (k < 400 && !got) begin
      @(negedge clk);
      k++;
      if (p0_ack === 1'b1 || p1_ack === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input int port, input logic [15:0] addr, input logic we,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input logic [39:0] exp_frame, input int fbits);
    int          n;
    int          k;
    logic        ce81;
    logic        got;
    logic [39:0] mask;
    sb.push_back('{port, exp_rd});
    @(negedge clk);
    if (port == 0) begin
      p0_req = 1'b1; p0_addr = addr;
    end else begin
      p1_req = 1'b1; p1_addr = addr; p1_we = we; p1_wdata = wd;
    end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 40'(n < 300), 40'd1);
    k = 0;
    ce81 = 1'b0;
    got = 1'b0;
    while (k < 300 && !got) begin
      @(negedge clk);
      k++;
      if (k == 81) ce81 = spi_ce;
      if (p0_ack === 1'b1 || p1_ack === 1'b1) got = 1'b1;
    end
    chk("latency", 40'(k), 40'd82);
    chk("ce_high_pre_ack", 40'(ce81), 40'd1);
    chk("both_acks", 40'(p0_ack & p1_ack), 40'd0);
    check_ack();
    mask = (fbits == 40) ? '1 : {32'hFFFF_FFFF, 8'h00};
    chk("mosi_frame", last_frame & mask, exp_frame & mask);
    chk("frame_bits", 40'(last_bits), 40'd40);
    chk("gap_pulse", 40'(last_gap), 40'd1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    p1_we  = 1'b0;
  endtask

  task automatic tie(input logic [15:0] a0, input logic [15:0] a1,
                     input logic [7:0] e0, input logic [7:0] e1);
    logic got;
    sb.push_back('{0, e0});
    sb.push_back('{1, e1});
    @(negedge clk);
    p0_req = 1'b1; p0_addr = a0;
    p1_req = 1'b1; p1_addr = a1; p1_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_ack(got);
      chk("tie_ack_seen", 40'(got), 40'd1);
      chk("both_acks", 40'(p0_ack & p1_ack), 40'd0);
      check_ack();
      if (p0_ack === 1'b1) p0_req = 1'b0;
      if (p1_ack === 1'b1) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  initial begin
    int n;
    int acks;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ce",    40'(spi_ce),   40'd1);
    chk("rst_clk",   40'(spi_clk),  40'd0);
    chk("rst_mosi",  40'(spi_mosi), 40'd0);
    chk("rst_acks",  40'({p1_ack, p0_ack}), 40'd0);
    chk("rst_rdata", 40'(rdata),    40'd0);
    chk("rst_busy",  40'(busy),     40'd1);
    rst = 1'b0;

    // Single fetch read.
    do_txn(0, 16'h0003, 1'b0, 8'h00, 8'h04, {8'h03, 24'h000003, 8'h00}, 32);

    // Simultaneous requests after reset: p0 first, then p1; next tie p0 again.
    do_reset();
    tie(16'h0000, 16'h0005, 8'h01, 8'h06);
    tie(16'h0002, 16'h0004, 8'h03, 8'h05);

    // Back-to-back data reads.
    do_txn(1, 16'h0001, 1'b0, 8'h00, 8'h02, {8'h03, 24'h000001, 8'h00}, 32);
    do_txn(1, 16'h0002, 1'b0, 8'h00, 8'h03, {8'h03, 24'h000002, 8'h00}, 32);

    // Reset in the middle of a fetch read.
    @(negedge clk);
    p0_req = 1'b1;
    p0_addr = 16'h0003;
    n = 0;
    while (m_bits != 20 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bit20_reached", 40'(n < 300), 40'd1);
    #2 rst = 1'b1;
    #1;
    chk("ce_on_rst",  40'(spi_ce),  40'd1);
    chk("clk_on_rst", 40'(spi_clk), 40'd0);
    p0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (p0_ack === 1'b1 || p1_ack === 1'b1) acks++;
    end
    chk("no_ack_after_rst", 40'(acks), 40'd0);
    do_txn(0, 16'h0007, 1'b0, 8'h00, 8'h08, {8'h03, 24'h000007, 8'h00}, 32);

    // Data-port write request.
`ifdef SPI_WRITE_EN
    do_txn(1, 16'h0010, 1'b1, 8'hA5, 8'h08, {8'h02, 24'h000010, 8'hA5}, 40);
`else
    do_txn(1, 16'h0010, 1'b1, 8'hA5, 8'h01, {8'h03, 24'h000010, 8'h00}, 32);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
